// File: rtl/fb_uart_loader.sv
// -----------------------------------------------------------------------------
// fb_uart_loader
//
// Converts the UART receiver byte stream into pixel writes for the 640x480
// frame buffer. A small packet parser handles two commands:
//   A5 01 b0 b1 b2 : set the pixel address, W = {b0,b1,b2}, h = W[18:9],
//                    v = W[8:0]
//   A5 02 R G B    : write one pixel at the current address, then advance the
//                    address (v first, then h, wrapping to (0,0))
// Finished pixels are queued in a FIFO. The FIFO drains into the memory write
// port only while the VGA scan is outside the active area (vga_valid = 0).
//
// Build option:
//   FB_LOADER_TIMEOUT_EN : when defined, a partial packet is abandoned after
//                          TIMEOUT_CYCLES clocks without a new byte.
//
// Ports:
//   clk        system / pixel clock
//   resetn     asynchronous active-low reset
//   rx_valid   one-cycle strobe qualifying rx_data
//   rx_data    received byte
//   vga_valid  scan owns the memory while high
//   wr_en      registered memory write strobe
//   wr_addr    registered {h[9:0], v[8:0]}
//   wr_data    registered {R, G, B}
//   busy       parser not idle or FIFO non-empty
//   err        sticky: bad command or out-of-range address
//   ovf        sticky: pixel dropped on a full FIFO
// -----------------------------------------------------------------------------
module fb_uart_loader #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        vga_valid,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        err,
  output logic        ovf
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [9:0]  H_LAST  = 10'd639;
  localparam logic [8:0]  V_LAST  = 9'd479;

  typedef enum logic [2:0] {
    IDLE, CMD, A0, A1, A2, PR, PG, PB
  } state_t;

  // Column-major advance: v runs fastest, matching the {h, v} memory order.
  function automatic logic [18:0] addr_inc(input logic [18:0] a);
    logic [9:0] h;
    logic [8:0] v;
    h = a[18:9];
    v = a[8:0];
    if (v == V_LAST) begin
      v = '0;
      h = (h == H_LAST) ? 10'd0 : h + 10'd1;
    end else begin
      v = v + 9'd1;
    end
    return {h, v};
  endfunction

  function automatic logic addr_in_range(input logic [18:0] a);
    return (a[18:9] <= H_LAST) && (a[8:0] <= V_LAST);
  endfunction

  state_t      state, state_nxt;
  logic [2:0]  a0_q;
  logic [7:0]  a1_q;
  logic [7:0]  r_q, g_q;
  logic [18:0] cur_addr;
  logic [18:0] ld_addr;

  logic        push_req, cmd_bad, addr_ld, addr_bad;
  logic        tmo_hit;

  logic [42:0] pix_p0;
  logic        vld_p0;
  logic        pop;

  logic [42:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Only the low three bits of the first address byte reach W[18:16].
  assign ld_addr = {a0_q, a1_q, rx_data};

`ifdef FB_LOADER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  // Fires in the TIMEOUT_CYCLES-th consecutive idle cycle of a packet, so the
  // parser is back in IDLE right after that many byte-free cycles.
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || rx_valid || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_param_unused
  end
`endif

  // Parser state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Parser next state
  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      case (state)
        IDLE:    if (rx_data == 8'hA5) state_nxt = CMD;
        CMD: begin
          if (rx_data == 8'h01)      state_nxt = A0;
          else if (rx_data == 8'h02) state_nxt = PR;
          else                       state_nxt = IDLE;
        end
        A0:      state_nxt = A1;
        A1:      state_nxt = A2;
        A2:      state_nxt = IDLE;
        PR:      state_nxt = PG;
        PG:      state_nxt = PB;
        PB:      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  // Parser outputs
  always_comb begin
    push_req = 1'b0;
    cmd_bad  = 1'b0;
    addr_ld  = 1'b0;
    addr_bad = 1'b0;
    if (rx_valid) begin
      case (state)
        CMD:     cmd_bad  = (rx_data != 8'h01) && (rx_data != 8'h02);
        A2: begin
          addr_ld  = addr_in_range(ld_addr);
          addr_bad = !addr_in_range(ld_addr);
        end
        PB:      push_req = 1'b1;
        default: ;
      endcase
    end
  end

  // Packet byte capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (state)
        A0:      a0_q <= rx_data[2:0];
        A1:      a1_q <= rx_data;
        PR:      r_q  <= rx_data;
        PG:      g_q  <= rx_data;
        default: ;
      endcase
    end
  end

  // The address advances on every completed pixel packet, accepted or dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_addr <= '0;
    end else if (addr_ld) begin
      cur_addr <= ld_addr;
    end else if (push_req) begin
      cur_addr <= addr_inc(cur_addr);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      err <= err | cmd_bad | addr_bad;
      ovf <= ovf | (push_req & ~vld_p0);
    end
  end

  // ---- stage p0: pixel push into the FIFO ----
  assign pop    = (count != '0) && !vga_valid;
  assign pix_p0 = {cur_addr, r_q, g_q, rx_data};
  // A full FIFO still accepts a push when an entry leaves in the same cycle.
  assign vld_p0 = push_req && ((count < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mem[wr_ptr] <= pix_p0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({vld_p0, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- stage p1: registered memory write port ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pop;
      if (pop) begin
        {wr_addr, wr_data} <= mem[rd_ptr];
      end
    end
  end

  assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_fb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_fb_uart_loader
//
// Directed bench for fb_uart_loader. Stimulus pushes the hand-computed
// expected writes into a scoreboard queue; an independent monitor on the
// falling edge pops and compares every wr_en cycle it sees.
// -----------------------------------------------------------------------------
module tb_fb_uart_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic        clk;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        vga_valid;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        err;
  logic        ovf;

  fb_uart_loader #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .vga_valid (vga_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .err       (err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    int          cyc;   // required monitor cycle, or -1 when not timed
  } exp_t;

  exp_t sb[$];
  int   wcyc[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic vv_q  = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (wr_en) begin
      wcyc.push_back(cyc);
      total++;
      if (vv_q) begin
        bad++;
        $display("FAIL wr_during_scan actual wr_en=1 required wr_en=0 (vga_valid was 1) cyc=%0d", cyc);
      end
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual addr=%05h data=%06h required no write", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          bad++;
          $display("FAIL write_value actual addr=%05h data=%06h required addr=%05h data=%06h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
        if (mon_e.cyc >= 0) begin
          total++;
          if (cyc != mon_e.cyc) begin
            bad++;
            $display("FAIL write_latency actual cyc=%0d required cyc=%0d", cyc, mon_e.cyc);
          end
        end
      end
    end
    vv_q = vga_valid;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_addr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(8'hA5); send(8'h01); send(b0); send(b1); send(b2);
  endtask

  task automatic send_px(input logic [23:0] rgb);
    logic [23:0] p;
    p = rgb;
    send(8'hA5); send(8'h02); send(p[23:16]); send(p[15:8]); send(p[7:0]);
  endtask

  task automatic expect_px(input logic [18:0] a, input logic [23:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s drain_timeout actual pending=%0d required pending=0", nm, sb.size());
      sb.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    resetn    = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    vga_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {13'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {8'd0, wr_data}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_err",     {31'd0, err}, 32'd0);
    check("rst_ovf",     {31'd0, ovf}, 32'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // Stray byte in IDLE is ignored
    send(8'h42);
    tick();
    check("stray_err",  {31'd0, err}, 32'd0);
    check("stray_busy", {31'd0, busy}, 32'd0);

    // Basic write: address (1,3), pixel 112233, write two cycles after B byte
    send_addr(8'h00, 8'h02, 8'h03);
    check("basic_busy_idle", {31'd0, busy}, 32'd0);
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    check("basic_busy_mid", {31'd0, busy}, 32'd1);
    send(8'h33);
    expect_px(19'h00203, 24'h112233, cyc + 1);
    wait_drain("basic");
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    check("basic_err", {31'd0, err}, 32'd0);

    // Wrap: (639,479) then (0,0)
    send_addr(8'h04, 8'hFF, 8'hDF);
    send_px(24'h010203);
    expect_px(19'h4FFDF, 24'h010203, cyc + 1);
    send_px(24'h040506);
    expect_px(19'h00000, 24'h040506, cyc + 1);
    wait_drain("wrap");
    check("wrap_err", {31'd0, err}, 32'd0);

    // Arbitration: three pixels held while the scan owns the memory
    send_addr(8'h00, 8'h0A, 8'h0A);
    vga_valid = 1'b1;
    wcyc.delete();
    send_px(24'h102030); expect_px(19'h00A0A, 24'h102030, -1);
    send_px(24'h405060); expect_px(19'h00A0B, 24'h405060, -1);
    send_px(24'h708090); expect_px(19'h00A0C, 24'h708090, -1);
    repeat (5) tick();
    check("arb_no_write", wcyc.size(), 32'd0);
    check("arb_busy", {31'd0, busy}, 32'd1);
    vga_valid = 1'b0;
    wait_drain("arb");
    check("arb_count", wcyc.size(), 32'd3);
    if (wcyc.size() == 3) begin
      check("arb_b2b_1", wcyc[1] - wcyc[0], 32'd1);
      check("arb_b2b_2", wcyc[2] - wcyc[1], 32'd1);
    end

    // Overflow: FIFO_DEPTH+1 pixels starting at (2,478); the fifth is dropped
    send_addr(8'h00, 8'h05, 8'hDE);
    vga_valid = 1'b1;
    wcyc.delete();
    send_px(24'h111111); expect_px(19'h005DE, 24'h111111, -1);
    send_px(24'h222222); expect_px(19'h005DF, 24'h222222, -1);
    send_px(24'h333333); expect_px(19'h00600, 24'h333333, -1);
    send_px(24'h444444); expect_px(19'h00601, 24'h444444, -1);
    check("ovf_before_full", {31'd0, ovf}, 32'd0);
    send_px(24'h555555);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check("ovf_no_err", {31'd0, err}, 32'd0);
    repeat (2) tick();
    vga_valid = 1'b0;
    wait_drain("ovf");
    check("ovf_write_count", wcyc.size(), 32'd4);
    send_px(24'h666666);
    expect_px(19'h00603, 24'h666666, cyc + 1);
    wait_drain("ovf_next");

`ifdef FB_LOADER_TIMEOUT_EN
    // Timeout: partial packet abandoned, next packet parsed cleanly
    wcyc.delete();
    send(8'hA5); send(8'h02); send(8'h11);
    repeat (TMO) tick();
    check("tmo_idle_busy", {31'd0, busy}, 32'd0);
    send_px(24'hAABBCC);
    expect_px(19'h00604, 24'hAABBCC, cyc + 1);
    wait_drain("tmo");
    check("tmo_single", wcyc.size(), 32'd1);
    check("tmo_err", {31'd0, err}, 32'd0);
`endif

    // Reset mid-drain: first entry is on the write port when reset hits
    send_addr(8'h00, 8'h12, 8'h01);
    vga_valid = 1'b1;
    send_px(24'h0000FF);
    send_px(24'h00FF00);
    send_px(24'hFF0000);
    expect_px(19'h01201, 24'h0000FF, -1);
    vga_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    check("mid_wr_en_pre", {31'd0, wr_en}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_wr_en",   {31'd0, wr_en}, 32'd0);
    check("mid_rst_wr_addr", {13'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", {8'd0, wr_data}, 32'd0);
    check("mid_rst_busy",    {31'd0, busy}, 32'd0);
    check("mid_rst_ovf",     {31'd0, ovf}, 32'd0);
    tick();
    resetn = 1'b1;
    wcyc.delete();
    repeat (8) tick();
    check("mid_discarded", wcyc.size(), 32'd0);
    check("mid_sb_empty", sb.size(), 32'd0);
    send_px(24'h123456);
    expect_px(19'h00000, 24'h123456, cyc + 1);
    wait_drain("mid");

    // Bad command
    send(8'hA5); send(8'h07);
    tick();
    check("badcmd_err", {31'd0, err}, 32'd1);
    check("badcmd_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b0;
    tick();
    check("err_cleared", {31'd0, err}, 32'd0);
    resetn = 1'b1;
    tick();

    // Out-of-range h=640 keeps the old address (7,7)
    send_addr(8'h00, 8'h0E, 8'h07);
    check("inrange_err", {31'd0, err}, 32'd0);
    send_addr(8'h05, 8'h00, 8'h00);
    check("h640_err", {31'd0, err}, 32'd1);
    send_px(24'hABCDEF);
    expect_px(19'h00E07, 24'hABCDEF, cyc + 1);
    wait_drain("h640");

    check("final_sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
